// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared flag indices, branch-select encodings and flags type
package cpu_pkg;

    // Bit positions inside a {V,C,N,Z} flag vector
    localparam int FLG_Z = 0;
    localparam int FLG_N = 1;
    localparam int FLG_C = 2;
    localparam int FLG_V = 3;

    // Encodings of the branch flag-under-test selector
    typedef enum logic [1:0] {
        BR_Z = 2'b00,
        BR_N = 2'b01,
        BR_C = 2'b10,
        BR_V = 2'b11
    } br_sel_e;

    // Condition-code vector ordered {V,C,N,Z}
    typedef logic [3:0] flags_t;

endpackage

// File: rtl/ccr_shadow_stack.sv
// rtl/ccr_shadow_stack.sv - LIFO of saved flag sets for interrupt nesting
//
// Ports:
//   clk, rst     clock, synchronous active-high reset
//   save_i       interrupt-entry push request
//   restore_i    return-from-interrupt pop request (wins over save_i)
//   push_data_i  flag set to push
//   pop_data_o   top-of-stack entry, meaningful while pop_valid_o is high
//   pop_valid_o  a pop actually happens this cycle (restore_i and not empty)
//   full_o       DEPTH entries held
//   empty_o      no entries held
//   err_o        sticky: push-when-full, pop-when-empty, or save+restore together
module ccr_shadow_stack
    import cpu_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   save_i,
    input  logic   restore_i,
    input  flags_t push_data_i,
    output flags_t pop_data_o,
    output logic   pop_valid_o,
    output logic   full_o,
    output logic   empty_o,
    output logic   err_o
);

    localparam int SP_W  = $clog2(DEPTH + 1);
    // Storage is sized to the full pointer range so sp can index it directly
    localparam int MEM_N = 1 << SP_W;

    flags_t            mem_q [MEM_N];
    logic [SP_W-1:0]   sp_q, sp_d;
    logic              err_q, err_d;
    logic              full_w, empty_w;
    logic              do_push, do_pop;

    assign full_w  = (sp_q == SP_W'(DEPTH));
    assign empty_w = (sp_q == '0);

    assign do_pop  = restore_i & ~empty_w;
    assign do_push = save_i & ~restore_i & ~full_w;

    always_comb begin
        sp_d  = sp_q;
        err_d = err_q;
        if (do_pop) begin
            sp_d = sp_q - SP_W'(1);
        end else if (do_push) begin
            sp_d = sp_q + SP_W'(1);
        end
        // A save that collides with a restore is dropped and flagged as well
        if ((save_i & restore_i) | (save_i & full_w) | (restore_i & empty_w)) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sp_q  <= '0;
            err_q <= 1'b0;
        end else begin
            sp_q  <= sp_d;
            err_q <= err_d;
        end
    end

    // Entries are don't-care after reset, so the array carries no reset
    always_ff @(posedge clk) begin
        if (!rst && do_push) begin
            mem_q[sp_q] <= push_data_i;
        end
    end

    assign pop_data_o  = mem_q[sp_q - SP_W'(1)];
    assign pop_valid_o = do_pop;
    assign full_o      = full_w;
    assign empty_o     = empty_w;
    assign err_o       = err_q;

endmodule

// File: rtl/ccr_unit.sv
// rtl/ccr_unit.sv - condition-code register with branch test and interrupt shadow stack
//
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   alu_flags     ALU results {V,C,N,Z}
//   flag_mask     per-bit write enable {V,C,N,Z}, qualified by flag_we
//   flag_we       instruction commit
//   br_en/br_sel  conditional branch and flag under test (Z,N,C,V)
//   int_save      push next-state flags onto the shadow stack
//   rti_restore   pop the shadow stack into the CCR
//   flags, cin    registered CCR and its carry bit for the ALU
//   br_taken      combinational branch decision on registered flags
//   shadow_full/shadow_empty/shadow_err  shadow stack status
module ccr_unit
    import cpu_pkg::*;
#(
    parameter int SHADOW_DEPTH = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] alu_flags,
    input  logic [3:0] flag_mask,
    input  logic       flag_we,
    input  logic       br_en,
    input  logic [1:0] br_sel,
    input  logic       int_save,
    input  logic       rti_restore,
    output logic [3:0] flags,
    output logic       cin,
    output logic       br_taken,
    output logic       shadow_full,
    output logic       shadow_empty,
    output logic       shadow_err
);

    flags_t flags_q, flags_d;
    flags_t upd;
    flags_t pop_data;
    logic   pop_valid;

    assign br_taken = br_en & flags_q[br_sel];

    always_comb begin
        upd = flags_q;
        for (int i = 0; i < 4; i++) begin
            if (flag_we && flag_mask[i]) begin
                upd[i] = alu_flags[i];
            end
        end
        // Consuming a taken branch's flag beats a same-cycle ALU write to it
        if (br_taken) begin
            upd[br_sel] = 1'b0;
        end
        flags_d = pop_valid ? pop_data : upd;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            flags_q <= '0;
        end else begin
            flags_q <= flags_d;
        end
    end

    // The pushed value is upd so the interrupted instruction's flag effects survive
    ccr_shadow_stack #(
        .DEPTH (SHADOW_DEPTH)
    ) u_shadow (
        .clk         (clk),
        .rst         (rst),
        .save_i      (int_save),
        .restore_i   (rti_restore),
        .push_data_i (upd),
        .pop_data_o  (pop_data),
        .pop_valid_o (pop_valid),
        .full_o      (shadow_full),
        .empty_o     (shadow_empty),
        .err_o       (shadow_err)
    );

    assign flags = flags_q;
    assign cin   = flags_q[FLG_C];

endmodule

// File: tb/tb_ccr_unit.sv
// tb/tb_ccr_unit.sv - directed self-checking bench for ccr_unit
module tb_ccr_unit;

    logic       clk;
    logic       rst;
    logic [3:0] alu_flags;
    logic [3:0] flag_mask;
    logic       flag_we;
    logic       br_en;
    logic [1:0] br_sel;
    logic       int_save;
    logic       rti_restore;
    logic [3:0] flags;
    logic       cin;
    logic       br_taken;
    logic       shadow_full;
    logic       shadow_empty;
    logic       shadow_err;

    int total = 0;
    int bad   = 0;

    ccr_unit #(.SHADOW_DEPTH(2)) dut (
        .clk          (clk),
        .rst          (rst),
        .alu_flags    (alu_flags),
        .flag_mask    (flag_mask),
        .flag_we      (flag_we),
        .br_en        (br_en),
        .br_sel       (br_sel),
        .int_save     (int_save),
        .rti_restore  (rti_restore),
        .flags        (flags),
        .cin          (cin),
        .br_taken     (br_taken),
        .shadow_full  (shadow_full),
        .shadow_empty (shadow_empty),
        .shadow_err   (shadow_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic idle();
        rst = 0; alu_flags = 4'b0000; flag_mask = 4'b0000; flag_we = 0;
        br_en = 0; br_sel = 2'b00; int_save = 0; rti_restore = 0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle();
        rst = 1;
        step();
        rst = 0;
    endtask

    task automatic load_flags(input logic [3:0] v);
        idle();
        flag_we = 1; flag_mask = 4'b1111; alu_flags = v;
        step();
        idle();
    endtask

    task automatic test_reset();
        do_reset();
        total++; if (flags !== 4'b0000) begin bad++; $display("FAIL reset_flags got=%b exp=0000", flags); end
        total++; if (cin !== 1'b0) begin bad++; $display("FAIL reset_cin got=%b exp=0", cin); end
        total++; if (shadow_empty !== 1'b1) begin bad++; $display("FAIL reset_empty got=%b exp=1", shadow_empty); end
        total++; if (shadow_full !== 1'b0) begin bad++; $display("FAIL reset_full got=%b exp=0", shadow_full); end
        total++; if (shadow_err !== 1'b0) begin bad++; $display("FAIL reset_err got=%b exp=0", shadow_err); end
        total++; if (br_taken !== 1'b0) begin bad++; $display("FAIL reset_br_taken got=%b exp=0", br_taken); end
    endtask

    task automatic test_alu_update();
        idle();
        alu_flags = 4'b1111; flag_mask = 4'b0101; flag_we = 1;
        step();
        total++; if (flags !== 4'b0101) begin bad++; $display("FAIL mask_write got=%b exp=0101", flags); end
        total++; if (cin !== 1'b1) begin bad++; $display("FAIL mask_cin got=%b exp=1", cin); end
        alu_flags = 4'b0000; flag_mask = 4'b0101; flag_we = 0;
        step();
        total++; if (flags !== 4'b0101) begin bad++; $display("FAIL we_low_hold got=%b exp=0101", flags); end
        // Masked-off bits keep value while others change
        alu_flags = 4'b0000; flag_mask = 4'b1010; flag_we = 1;
        step();
        total++; if (flags !== 4'b0101) begin bad++; $display("FAIL mask_zero_bits got=%b exp=0101", flags); end
        alu_flags = 4'b0000; flag_mask = 4'b0100; flag_we = 1;
        step();
        total++; if (cin !== 1'b0) begin bad++; $display("FAIL cin_cleared got=%b exp=0", cin); end
        idle();
    endtask

    task automatic test_branch();
        load_flags(4'b0001);
        br_en = 1; br_sel = 2'b00;
        #1;
        total++; if (br_taken !== 1'b1) begin bad++; $display("FAIL br_z_taken got=%b exp=1", br_taken); end
        step();
        total++; if (flags !== 4'b0000) begin bad++; $display("FAIL br_z_clear got=%b exp=0000", flags); end
        total++; if (br_taken !== 1'b0) begin bad++; $display("FAIL br_z_retest got=%b exp=0", br_taken); end
        // V selected but clear, N set: branch on V not taken, flags untouched
        idle();
        load_flags(4'b0010);
        br_en = 1; br_sel = 2'b11;
        #1;
        total++; if (br_taken !== 1'b0) begin bad++; $display("FAIL br_v_not_taken got=%b exp=0", br_taken); end
        br_sel = 2'b01;
        #1;
        total++; if (br_taken !== 1'b1) begin bad++; $display("FAIL br_n_taken got=%b exp=1", br_taken); end
        step();
        total++; if (flags !== 4'b0000) begin bad++; $display("FAIL br_n_clear got=%b exp=0000", flags); end
        idle();
    endtask

    task automatic test_clear_vs_write();
        load_flags(4'b0100);
        br_en = 1; br_sel = 2'b10; flag_we = 1; flag_mask = 4'b0100; alu_flags = 4'b0100;
        #1;
        total++; if (br_taken !== 1'b1) begin bad++; $display("FAIL clr_vs_wr_taken got=%b exp=1", br_taken); end
        step();
        total++; if (flags !== 4'b0000) begin bad++; $display("FAIL clr_vs_wr_flags got=%b exp=0000", flags); end
        idle();
    endtask

    task automatic test_nested();
        do_reset();
        load_flags(4'b1010);
        int_save = 1;
        step();
        int_save = 0;
        total++; if (shadow_empty !== 1'b0) begin bad++; $display("FAIL nest1_empty got=%b exp=0", shadow_empty); end
        total++; if (shadow_full !== 1'b0) begin bad++; $display("FAIL nest1_full got=%b exp=0", shadow_full); end
        total++; if (flags !== 4'b1010) begin bad++; $display("FAIL nest1_flags got=%b exp=1010", flags); end
        load_flags(4'b0011);
        int_save = 1;
        step();
        total++; if (shadow_full !== 1'b1) begin bad++; $display("FAIL nest2_full got=%b exp=1", shadow_full); end
        total++; if (shadow_err !== 1'b0) begin bad++; $display("FAIL nest2_err got=%b exp=0", shadow_err); end
        // Third push overflows: dropped, error set, CCR still loads upd
        flag_we = 1; flag_mask = 4'b1111; alu_flags = 4'b0011;
        step();
        idle();
        total++; if (shadow_err !== 1'b1) begin bad++; $display("FAIL nest3_err got=%b exp=1", shadow_err); end
        total++; if (shadow_full !== 1'b1) begin bad++; $display("FAIL nest3_full got=%b exp=1", shadow_full); end
        load_flags(4'b1111);
        rti_restore = 1;
        step();
        total++; if (flags !== 4'b0011) begin bad++; $display("FAIL rti1_flags got=%b exp=0011", flags); end
        total++; if (shadow_full !== 1'b0) begin bad++; $display("FAIL rti1_full got=%b exp=0", shadow_full); end
        // ALU write in the restore cycle is discarded
        flag_we = 1; flag_mask = 4'b1111; alu_flags = 4'b0101;
        step();
        idle();
        total++; if (flags !== 4'b1010) begin bad++; $display("FAIL rti2_flags got=%b exp=1010", flags); end
        total++; if (shadow_empty !== 1'b1) begin bad++; $display("FAIL rti2_empty got=%b exp=1", shadow_empty); end
        total++; if (shadow_err !== 1'b1) begin bad++; $display("FAIL rti2_err_sticky got=%b exp=1", shadow_err); end
    endtask

    task automatic test_pop_empty();
        do_reset();
        rti_restore = 1; flag_we = 1; flag_mask = 4'b1111; alu_flags = 4'b0110;
        step();
        idle();
        total++; if (flags !== 4'b0110) begin bad++; $display("FAIL pop_empty_flags got=%b exp=0110", flags); end
        total++; if (shadow_err !== 1'b1) begin bad++; $display("FAIL pop_empty_err got=%b exp=1", shadow_err); end
        total++; if (shadow_empty !== 1'b1) begin bad++; $display("FAIL pop_empty_empty got=%b exp=1", shadow_empty); end
    endtask

    task automatic test_save_restore_and_reset();
        do_reset();
        load_flags(4'b1100);
        int_save = 1;
        step();
        idle();
        load_flags(4'b0011);
        int_save = 1; rti_restore = 1;
        step();
        idle();
        total++; if (flags !== 4'b1100) begin bad++; $display("FAIL sr_flags got=%b exp=1100", flags); end
        total++; if (shadow_empty !== 1'b1) begin bad++; $display("FAIL sr_empty got=%b exp=1", shadow_empty); end
        total++; if (shadow_err !== 1'b1) begin bad++; $display("FAIL sr_err got=%b exp=1", shadow_err); end
        // Reset while mid-interrupt with activity on every input
        load_flags(4'b0111);
        int_save = 1;
        step();
        rst = 1; int_save = 1; flag_we = 1; flag_mask = 4'b1111; alu_flags = 4'b1111;
        step();
        idle();
        total++; if (flags !== 4'b0000) begin bad++; $display("FAIL rst_mid_flags got=%b exp=0000", flags); end
        total++; if (cin !== 1'b0) begin bad++; $display("FAIL rst_mid_cin got=%b exp=0", cin); end
        total++; if (shadow_empty !== 1'b1) begin bad++; $display("FAIL rst_mid_empty got=%b exp=1", shadow_empty); end
        total++; if (shadow_full !== 1'b0) begin bad++; $display("FAIL rst_mid_full got=%b exp=0", shadow_full); end
        total++; if (shadow_err !== 1'b0) begin bad++; $display("FAIL rst_mid_err got=%b exp=0", shadow_err); end
        total++; if (br_taken !== 1'b0) begin bad++; $display("FAIL rst_mid_br got=%b exp=0", br_taken); end
    endtask

    initial begin
        idle();
        test_reset();
        test_alu_update();
        test_branch();
        test_clear_vs_write();
        test_nested();
        test_pop_empty();
        test_save_restore_and_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ccr_unit.md
# ccr_unit

Condition-code register stage directly downstream of the ALU. Latches the ALU's V/C/N/Z results under the ALU's per-operation flag mask and feeds the registered carry back as the ALU carry-in. Evaluates conditional-branch flag tests and clears the tested flag on a taken branch. Holds a small LIFO of saved flag sets for interrupt entry (`int_save`) and return (`rti_restore`).

## Interface
Parameters:
- `SHADOW_DEPTH`, 2: number of saved flag sets, i.e. nested interrupt levels; must be ≥ 1.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `alu_flags`  in  4  ALU flag results, ordered `{V,C,N,Z}`.
- `flag_mask`  in  4  per-bit write enable from the ALU, ordered `{V,C,N,Z}`.
- `flag_we`  in  1  instruction commit; the mask is ignored when low.
- `br_en`  in  1  current instruction is a conditional branch.
- `br_sel`  in  2  flag under test: 00=Z, 01=N, 10=C, 11=V.
- `int_save`  in  1  push the next-state flags onto the shadow LIFO.
- `rti_restore`  in  1  pop the shadow LIFO into the CCR.
- `flags`  out  4  registered CCR, ordered `{V,C,N,Z}`.
- `cin`  out  1  equals `flags[2]` (C); drives the ALU carry-in.
- `br_taken`  out  1  combinational: `br_en & flags[br_sel]`.
- `shadow_full`  out  1  LIFO holds `SHADOW_DEPTH` entries.
- `shadow_empty`  out  1  LIFO holds 0 entries.
- `shadow_err`  out  1  sticky flag; set on push-when-full or pop-when-empty.

## Operation
- Next-state computation, in this order:
  - **ALU update:** `upd[i] = (flag_we & flag_mask[i]) ? alu_flags[i] : flags[i]`. Bits with mask 0 keep their value.
  - **Branch clear:** if `br_taken`, bit `br_sel` of `upd` is forced to 0. Clear beats a same-cycle ALU write to that bit.
  - **Restore:** if `rti_restore` and the LIFO is not empty, `next` = top entry and the LIFO pops. In this case ALU update and branch clear are discarded. Otherwise `next = upd`.
- **Save:** if `int_save` and not `rti_restore`:
  - LIFO not full: push `upd`, so the interrupted instruction's own flag effects are preserved.
  - LIFO full: push dropped, `shadow_err` set, CCR still loads `upd`.
- **Save and restore together:** restore wins, save is dropped, `shadow_err` set.
- **Pop when empty:** `flags <= upd`, `shadow_err` set.
- The LIFO is a stack pointer `sp` in the range 0..`SHADOW_DEPTH`.
  - Push writes `mem[sp]` and increments `sp`.
  - Pop reads `mem[sp-1]` and decrements `sp`.
  - `sp` never wraps.

## Timing
- Reset (synchronous): on the edge with `rst`=1:
  - `flags`=0000, `sp`=0, `shadow_err`=0.
  - Therefore `cin`=0, `shadow_empty`=1, `shadow_full`=0.
  - `br_taken` follows its inputs (0 after reset when `br_en`=0).
  - Reset overrides every other input that cycle, including mid-interrupt; saved contents are discarded and LIFO memory contents are don't-care.
- Flag update latency: 1 cycle. Flags are written at the edge ending the instruction's cycle and are visible to the next instruction, so `cin` for an RLC/RRC reflects the previous instruction's carry.
- `br_taken` has 0-cycle latency and uses the registered flags. The flag clear appears 1 cycle later.
- Restore latency: 1 cycle. `flags` shows the popped value on the cycle after `rti_restore`.
- `shadow_full`, `shadow_empty`, `shadow_err` are registered and change on the same edge as `sp`.
- No handshake: each input is sampled on every edge and has no effect when low.

## Structure
- Shared package `cpu_pkg`:
  - flag bit indices `FLG_Z`=0, `FLG_N`=1, `FLG_C`=2, `FLG_V`=3;
  - `br_sel` encodings `BR_Z`, `BR_N`, `BR_C`, `BR_V`;
  - a 4-bit flags typedef.
- The ALU uses the same `{V,C,N,Z}` ordering for `flag_mask`.
- Sub-module `ccr_shadow_stack` (parameter `DEPTH`) contains the LIFO storage, `sp`, the full/empty flags and error detection.
- `ccr_unit` contains the next-state priority logic, the CCR register and branch evaluation.

## Test plan
- Reset, then `alu_flags`=1111, `flag_mask`=0101, `flag_we`=1 → next cycle `flags`=0101, `cin`=1. Repeat with `flag_we`=0 and `alu_flags`=0000 → `flags` stays 0101.
- `flags`=0001, `br_en`=1, `br_sel`=00 → `br_taken`=1 the same cycle, `flags`=0000 next cycle. Then `br_sel`=00 again → `br_taken`=0.
- Branch clear vs ALU write: `flags`=0100, `br_sel`=10, `br_en`=1, `flag_we`=1, `flag_mask`=0100, `alu_flags`=0100 → `flags`=0000.
- Nested interrupts with `SHADOW_DEPTH`=2, `flags`=1010:
  - `int_save` → `sp`=1; set `flags` to 0011; `int_save` → `shadow_full`=1.
  - Third `int_save` → `shadow_err`=1, `sp` stays 2.
  - Two `rti_restore` pulses → `flags`=0011, then 1010; `shadow_empty`=1.
- Pop when empty: `rti_restore` with `flag_we`=1, `flag_mask`=1111, `alu_flags`=0110 → `flags`=0110, `shadow_err`=1.
- Same-cycle `int_save` + `rti_restore` with `sp`=1 → pop occurs, `shadow_err`=1. Assert `rst` mid-sequence → all outputs return to reset values next cycle.
